// File: rtl/serial_operand_serializer_pkg.sv
// Shared types and defaults for the serial operand serializer.
//   state_t              : FSM encoding (IDLE, CLR, SHIFT)
//   SERIAL_WIDTH_DEFAULT : default operand width
package serial_pkg;
  typedef enum logic [1:0] {IDLE, CLR, SHIFT} state_t;
  localparam int SERIAL_WIDTH_DEFAULT = 8;
endpackage

// File: rtl/serial_operand_serializer_if.sv
// Operand-in / bit-stream-out bus of the serial operand serializer.
//   in_valid/in_ready/in_a/in_b : operand pair handshake (upstream -> block)
//   ser_clr                     : carry-clear pulse, one cycle before bit 0
//   ser_a/ser_b/ser_valid       : current bit pair and its qualifier
//   ser_first/ser_last          : bit 0 / bit WIDTH-1 markers
// master = operand source + stream consumer, slave = serializer.
interface serial_operand_serializer_if
  import serial_pkg::*;
#(
  parameter int WIDTH = SERIAL_WIDTH_DEFAULT
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             ser_clr;
  logic             ser_a;
  logic             ser_b;
  logic             ser_valid;
  logic             ser_first;
  logic             ser_last;

  modport master (
    output in_valid, in_a, in_b,
    input  in_ready, ser_clr, ser_a, ser_b, ser_valid, ser_first, ser_last
  );

  modport slave (
    input  in_valid, in_a, in_b,
    output in_ready, ser_clr, ser_a, ser_b, ser_valid, ser_first, ser_last
  );
endinterface

// File: rtl/serial_operand_serializer_piso_shift_reg.sv
// Parallel-in serial-out shift register, LSB first.
//   clk, rst : clock, synchronous active-high reset
//   i_load   : load i_d (has priority over i_shift)
//   i_shift  : shift right by one, zero fill at the MSB
//   i_d      : parallel data
//   o_lsb    : current LSB
module piso_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_d,
  output logic             o_lsb
);
  logic [WIDTH-1:0] r_sh;

  always_ff @(posedge clk) begin
    if (rst)          r_sh <= '0;
    else if (i_load)  r_sh <= i_d;
    else if (i_shift) r_sh <= {1'b0, r_sh[WIDTH-1:1]};
  end

  assign o_lsb = r_sh[0];
endmodule

// File: rtl/serial_operand_serializer.sv
// Serializes WIDTH-bit operand pairs LSB-first for a 1-bit serial adder.
// Each word costs one CLR cycle (ser_clr, used to zero the adder carry)
// followed by WIDTH SHIFT cycles. A new word can be accepted on the last
// bit cycle, so back-to-back words run at WIDTH+1 cycles per word.
//   clk, rst : clock, synchronous active-high reset
//   bus      : serial_operand_serializer_if.slave (handshake + bit stream)
module serial_operand_serializer
  import serial_pkg::*;
#(
  parameter int WIDTH = SERIAL_WIDTH_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst,
  serial_operand_serializer_if.slave  bus
);
  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_ser_clr;
  logic          r_ser_valid;

  logic w_last;
  logic w_ready;
  logic w_xfer;
  logic w_a_lsb;
  logic w_b_lsb;

  // r_ser_valid is high exactly in SHIFT, so it doubles as the state decode.
  assign w_last  = r_ser_valid && (r_cnt == LAST);
  assign w_ready = (r_state == IDLE) || w_last;
  assign w_xfer  = bus.in_valid && w_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_ser_clr   <= 1'b0;
      r_ser_valid <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_xfer) begin
            r_state   <= CLR;
            r_ser_clr <= 1'b1;
          end
        end
        CLR: begin
          r_state     <= SHIFT;
          r_cnt       <= '0;
          r_ser_clr   <= 1'b0;
          r_ser_valid <= 1'b1;
        end
        SHIFT: begin
          if (r_cnt == LAST) begin
            r_ser_valid <= 1'b0;
            if (w_xfer) begin
              r_state   <= CLR;
              r_ser_clr <= 1'b1;
            end else begin
              r_state   <= IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_ser_clr   <= 1'b0;
          r_ser_valid <= 1'b0;
        end
      endcase
    end
  end

  // Load on transfer wins over the final shift of the previous word.
  piso_shift_reg #(.WIDTH(WIDTH)) u_sh_a (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_xfer),
    .i_shift (r_ser_valid),
    .i_d     (bus.in_a),
    .o_lsb   (w_a_lsb)
  );

  piso_shift_reg #(.WIDTH(WIDTH)) u_sh_b (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_xfer),
    .i_shift (r_ser_valid),
    .i_d     (bus.in_b),
    .o_lsb   (w_b_lsb)
  );

  assign bus.in_ready  = w_ready;
  assign bus.ser_clr   = r_ser_clr;
  assign bus.ser_valid = r_ser_valid;
  assign bus.ser_a     = r_ser_valid & w_a_lsb;
  assign bus.ser_b     = r_ser_valid & w_b_lsb;
  assign bus.ser_first = r_ser_valid & (r_cnt == '0);
  assign bus.ser_last  = w_last;
endmodule

// File: tb/tb_serial_operand_serializer.sv
module tb_serial_operand_serializer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_operand_serializer_if #(.WIDTH(8)) if8 ();
  serial_operand_serializer_if #(.WIDTH(2)) if2 ();

  serial_operand_serializer #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));
  serial_operand_serializer #(.WIDTH(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Entered in the CLR cycle; returns positioned in the last-bit cycle.
  // Models the downstream adder (carry cleared by ser_clr) to rebuild the sum.
  task automatic stream8(input string tag, input logic [7:0] ea, input logic [7:0] eb,
                         input logic [7:0] esum, input bit jitter);
    logic       c;
    logic [7:0] s;
    logic       sa, sb;
    check($sformatf("%s.clr", tag), {if8.ser_clr, if8.ser_valid, if8.in_ready}, 3'b100);
    c = 1'b0;
    s = '0;
    if (jitter) begin
      if8.in_valid = 1'b1;
      if8.in_a     = 8'($urandom);
      if8.in_b     = 8'($urandom);
    end
    tick;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("%s.bit%0d", tag, i),
            {if8.ser_valid, if8.ser_clr, if8.ser_a, if8.ser_b,
             if8.ser_first, if8.ser_last, if8.in_ready},
            {1'b1, 1'b0, ea[i], eb[i], (i == 0), (i == 7), (i == 7)});
      sa   = if8.ser_a;
      sb   = if8.ser_b;
      s[i] = sa ^ sb ^ c;
      c    = (sa & sb) | (c & (sa ^ sb));
      if (jitter) begin
        if (i < 6) begin
          if8.in_valid = 1'b1;
          if8.in_a     = 8'($urandom);
          if8.in_b     = 8'($urandom);
        end else begin
          if8.in_valid = 1'b0;
        end
      end
      if (i < 7) tick;
    end
    check($sformatf("%s.sum", tag), {24'd0, s}, {24'd0, esum});
  endtask

  initial begin
    logic       c2;
    logic [1:0] s2;
    int         nf, nl;

    if8.in_valid = 1'b0; if8.in_a = '0; if8.in_b = '0;
    if2.in_valid = 1'b0; if2.in_a = '0; if2.in_b = '0;

    // Reset
    tick; tick;
    check("rst.outs", {if8.ser_valid, if8.ser_clr, if8.ser_a, if8.ser_b,
                       if8.ser_first, if8.ser_last}, 6'b000000);
    rst = 1'b0;
    tick;
    check("rst.release", {if8.ser_valid, if8.ser_clr, if8.in_ready}, 3'b001);

    // Single word, input changed after capture
    if8.in_a = 8'hA5; if8.in_b = 8'h3C; if8.in_valid = 1'b1;
    check("t1.ready", {31'd0, if8.in_ready}, 32'd1);
    tick;
    if8.in_valid = 1'b0; if8.in_a = 8'h00; if8.in_b = 8'hFF;
    stream8("t1", 8'hA5, 8'h3C, 8'hE1, 1'b0);
    tick;
    check("t1.idle", {if8.ser_valid, if8.ser_clr, if8.in_ready}, 3'b001);

    // Back-to-back with in_valid held high; carry must not leak into word 2
    if8.in_a = 8'hFF; if8.in_b = 8'h01; if8.in_valid = 1'b1;
    tick;
    if8.in_a = 8'h00; if8.in_b = 8'h00;
    stream8("b2b1", 8'hFF, 8'h01, 8'h00, 1'b0);
    tick;
    if8.in_valid = 1'b0;
    stream8("b2b2", 8'h00, 8'h00, 8'h00, 1'b0);
    tick;
    check("b2b.idle", {if8.ser_valid, if8.ser_clr, if8.in_ready}, 3'b001);

    // Backpressure: inputs churn while the word streams
    if8.in_a = 8'hC3; if8.in_b = 8'h96; if8.in_valid = 1'b1;
    tick;
    if8.in_valid = 1'b0;
    stream8("bp", 8'hC3, 8'h96, 8'h59, 1'b1);
    tick;
    check("bp.idle", {if8.ser_valid, if8.ser_clr, if8.in_ready}, 3'b001);

    // Reset in the middle of a word at bit 3
    if8.in_a = 8'h77; if8.in_b = 8'h11; if8.in_valid = 1'b1;
    tick;
    if8.in_valid = 1'b0;
    tick; tick; tick; tick;
    check("mid.bit3", {if8.ser_valid, if8.ser_a, if8.ser_b, if8.in_ready}, 4'b1000);
    rst = 1'b1;
    tick;
    check("mid.rst", {if8.ser_valid, if8.ser_clr, if8.ser_a, if8.ser_b,
                      if8.ser_first, if8.ser_last, if8.in_ready}, 7'b0000001);
    rst = 1'b0;
    tick;
    check("mid.after", {if8.ser_valid, if8.ser_clr, if8.in_ready}, 3'b001);
    if8.in_a = 8'h12; if8.in_b = 8'h34; if8.in_valid = 1'b1;
    tick;
    if8.in_valid = 1'b0;
    stream8("mid.new", 8'h12, 8'h34, 8'h46, 1'b0);
    tick;

    // WIDTH = 2
    if2.in_a = 2'b11; if2.in_b = 2'b01; if2.in_valid = 1'b1;
    check("w2.ready", {31'd0, if2.in_ready}, 32'd1);
    tick;
    if2.in_valid = 1'b0;
    nf = 0; nl = 0; c2 = 1'b0; s2 = '0;
    check("w2.clr", {if2.ser_clr, if2.ser_valid, if2.in_ready}, 3'b100);
    nf += int'(if2.ser_first); nl += int'(if2.ser_last);
    tick;
    check("w2.bit0", {if2.ser_valid, if2.ser_a, if2.ser_b, if2.ser_first,
                      if2.ser_last, if2.in_ready}, 6'b111100);
    nf += int'(if2.ser_first); nl += int'(if2.ser_last);
    s2[0] = if2.ser_a ^ if2.ser_b ^ c2;
    c2    = (if2.ser_a & if2.ser_b) | (c2 & (if2.ser_a ^ if2.ser_b));
    tick;
    check("w2.bit1", {if2.ser_valid, if2.ser_a, if2.ser_b, if2.ser_first,
                      if2.ser_last, if2.in_ready}, 6'b110011);
    nf += int'(if2.ser_first); nl += int'(if2.ser_last);
    s2[1] = if2.ser_a ^ if2.ser_b ^ c2;
    tick;
    check("w2.idle", {if2.ser_valid, if2.ser_clr, if2.in_ready}, 3'b001);
    nf += int'(if2.ser_first); nl += int'(if2.ser_last);
    check("w2.sum", {30'd0, s2}, 32'd0);
    check("w2.nfirst", nf, 32'd1);
    check("w2.nlast", nl, 32'd1);

    // Long idle
    for (int i = 0; i < 20; i++) begin
      check($sformatf("idle%0d", i), {if8.ser_valid, if8.ser_clr, if8.in_ready}, 3'b001);
      tick;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/serial_operand_serializer.md
Name: serial_operand_serializer

Overview:
Upstream feeder for the 1-bit serial adder. Accepts a pair of WIDTH-bit operands over a valid/ready handshake and streams them out LSB-first, one bit pair per cycle. Issues a one-cycle carry-clear pulse before each word so the downstream adder starts every word with carry = 0. Adder hookup: adder rst = rst | ser_clr, adder a/b = ser_a/ser_b.

Parameters:
WIDTH, 8, operand width in bits; legal range WIDTH >= 2.

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept a pair this cycle
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B
ser_clr  output  1  carry-clear pulse for downstream adder, one cycle before bit 0
ser_a  output  1  current bit of A
ser_b  output  1  current bit of B
ser_valid  output  1  ser_a/ser_b carry a valid bit
ser_first  output  1  current bit is bit 0 (LSB)
ser_last  output  1  current bit is bit WIDTH-1 (MSB)

Behaviour:
- Handshake: a transfer occurs on a posedge with in_valid & in_ready. in_ready is combinational from state only; it never depends on in_valid.
- in_ready = 1 in IDLE, and in SHIFT while ser_last = 1. Otherwise it is 0.
- FSM states: IDLE, CLR, SHIFT.
  - IDLE -> CLR on transfer.
  - CLR -> SHIFT unconditionally, after 1 cycle.
  - SHIFT stays for WIDTH cycles.
  - On the last SHIFT cycle: go to CLR if a transfer occurs that cycle, else go to IDLE.
- Capture: in_a/in_b are latched into shift registers on the transfer edge. Later input changes are ignored until the next transfer.
- Timing, transfer at edge k:
  - Cycle after k: ser_clr = 1, ser_valid = 0.
  - Bit i (i = 0..WIDTH-1) is presented in cycle k+2+i with ser_valid = 1.
  - ser_first = 1 only with i = 0; ser_last = 1 only with i = WIDTH-1.
- Latency: first bit appears 2 cycles after the accepting edge. Throughput: WIDTH+1 cycles per word. Back-to-back operation has no idle cycle beyond the CLR cycle.
- Shift: ser_a = a_sh[0], ser_b = b_sh[0]. Both registers shift right by 1 at the end of each SHIFT cycle.
- Bit counter: width $clog2(WIDTH). Cleared in CLR, incremented in SHIFT. ser_last = (cnt == WIDTH-1). The counter never wraps past WIDTH-1.
- When ser_valid = 0: ser_a, ser_b, ser_first, ser_last are forced to 0.
- ser_clr = 1 only in CLR. It is never asserted together with ser_valid.
- Reset values: state IDLE, ser_clr = 0, ser_valid = 0, ser_a = ser_b = 0, ser_first = ser_last = 0, counter 0, shift registers 0. in_ready = 1 in the first cycle after reset is released.
- Reset mid-operation: the word is aborted with no further bits or ser_clr. Outputs take reset values on the next cycle.
- in_valid high during CLR or non-last SHIFT: ignored, no transfer, data not sampled.
- in_valid held with no transfer: the block must not change the captured word.

Decomposition:
- Package serial_pkg:
  - state_t enum {IDLE, CLR, SHIFT};
  - SERIAL_WIDTH_DEFAULT = 8.
- One natural sub-module, piso_shift_reg (parallel load, shift right, LSB out), instantiated twice for A and B. The FSM and counter stay in the top.

Test Plan:
- Single word, WIDTH = 8, a = 8'hA5, b = 8'h3C:
  - ser_clr pulses 1 cycle after accept;
  - ser_a sequence is 1,0,1,0,0,1,0,1 and ser_b is 0,0,1,1,1,1,0,0;
  - adder sum bits reassemble to 8'hE1;
  - ser_first on bit 0, ser_last on bit 7.
- Back-to-back, in_valid held high:
  - word 8'hFF+8'h01 then 8'h00+8'h00;
  - second word accepted on the last-bit cycle, CLR follows immediately;
  - sums are 8'h00 then 8'h00, i.e. the carry from word 1 is cleared.
- Backpressure: change in_a/in_b every cycle while in_valid = 1 during SHIFT -> in_ready = 0 except the last bit; the streamed word equals the originally captured word.
- Reset at bit 3 of a word -> next cycle ser_valid = 0, ser_clr = 0, in_ready = 1; a new word 8'h12+8'h34 then yields sum 8'h46.
- WIDTH = 2, a = 2'b11, b = 2'b01 -> bits (1,1),(1,0); sum bits reassemble to 2'b00 (carry out dropped); ser_first and ser_last each pulse once.
- Idle with in_valid = 0 for 20 cycles -> ser_valid and ser_clr stay 0, in_ready stays 1.
